pc_update_unit: RTL and testbench
=================================

# pc_update_unit

Program-counter stage fed directly by the PC source multiplexer: holds the architectural PC, decides each cycle whether the mux output is committed (unconditional write or branch-condition write), captures EPC on exceptions, and times the instruction-fetch memory wait so the control unit can sequence on a single done pulse. It sits between the PC source mux and the instruction-memory address port, with the control unit driving its write and fetch strobes.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_LAT, 2, fetch wait cycles (0..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- pc_next  in  32  candidate PC from the PC source mux
- pc_write  in  1  unconditional PC write strobe
- pc_write_cond  in  1  conditional PC write strobe
- branch_op  in  2  00 beq, 01 bne, 10 ble, 11 bgt
- alu_zero  in  1  ALU zero flag
- alu_gt  in  1  ALU signed greater-than flag
- epc_write  in  1  capture exception PC
- fetch_req  in  1  start instruction fetch at current PC
- pc_out  out  32  current PC / memory address
- epc_out  out  32  exception PC
- pc_written  out  1  one-cycle pulse: PC committed
- align_exc  out  1  one-cycle pulse: misaligned target rejected
- fetch_busy  out  1  fetch wait in progress
- fetch_done  out  1  one-cycle pulse: instruction valid

## Operation
- cond: beq = alu_zero; bne = !alu_zero; ble = alu_zero | !alu_gt; bgt = alu_gt.
- take = pc_write | (pc_write_cond & cond).
- take & pc_next[1:0]==0: pc_out <= pc_next; pc_written <= 1.
- take & pc_next[1:0]!=0: pc_out unchanged; epc_out <= pc_out; align_exc <= 1; pc_written stays 0.
- epc_write (no align_exc this cycle): epc_out <= pc_out - 4, modulo 2^32 (pc_out=0 gives 32'hFFFF_FFFC).
- Simultaneous epc_write and align_exc: alignment capture wins.
- Fetch FSM states IDLE, WAIT, DONE:
  - IDLE: fetch_req -> WAIT, counter <= MEM_LAT-1; if MEM_LAT=0 -> DONE directly.
  - WAIT: fetch_busy=1; counter decrements; counter==0 -> DONE.
  - DONE: fetch_done=1 for one cycle -> IDLE.
  - fetch_req in WAIT or DONE ignored.
  - Committed PC write during WAIT: counter reloads to MEM_LAT-1 (fetch restarts at new PC). Write during DONE: no effect on FSM.
- Reset (async, any state): pc_out=RESET_PC, epc_out=0, state IDLE, counter 0, pc_written=align_exc=fetch_busy=fetch_done=0.

## Timing
- Strobes/flags sampled at rising edge; pc_out, epc_out, pulses valid the following cycle (1-cycle latency).
- fetch_req at edge N with MEM_LAT=L>0: fetch_busy high cycles N+1..N+L, fetch_done high cycle N+L+1.
- MEM_LAT=0: fetch_done high cycle N+1, fetch_busy never asserted.
- fetch_busy and fetch_done never high together; pc_written and align_exc never high together.
- Reset mid-fetch aborts immediately; no fetch_done emitted.

## Structure
- Package pc_update_pkg: branch_op encodings (BR_BEQ, BR_BNE, BR_BLE, BR_BGT), fetch state enum, EPC offset constant (4).
- Sub-module pc_branch_cond: combinational branch_op/alu_zero/alu_gt -> cond.
- PC/EPC registers, pulse regs and fetch FSM in top.

## Test plan
- Reset with RESET_PC=32'h0000_0100, release -> pc_out=0x100, epc_out=0, all pulses 0.
- pc_next=0x204, pc_write=1 -> next cycle pc_out=0x204, pc_written=1 one cycle; pc_write_cond=1, branch_op=bne, alu_zero=1 -> pc_out unchanged, no pulse.
- All four branch_op with (zero,gt) in {(1,0),(0,1),(0,0)} -> commit exactly when cond table holds.
- pc_out=0x40, pc_write=1, pc_next=0x46, epc_write=1 -> pc_out=0x40, epc_out=0x40, align_exc=1; then epc_write alone -> epc_out=0x3C.
- MEM_LAT=2, fetch_req -> busy 2 cycles, done cycle 3; repeat with pc_write committed in 2nd busy cycle -> busy extends, done 2 cycles after write.
- Reset asserted during WAIT -> fetch_busy drops asynchronously, no fetch_done; MEM_LAT=0 -> fetch_done on cycle after fetch_req.

Source files
------------

// File: rtl/pc_update_pkg.sv
// ============================================================================
// Module : pc_update_pkg
// Brief  : Shared encodings for the PC update stage (branch ops, fetch FSM).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_update_pkg;

   localparam logic [1:0] BR_BEQ = 2'b00;
   localparam logic [1:0] BR_BNE = 2'b01;
   localparam logic [1:0] BR_BLE = 2'b10;
   localparam logic [1:0] BR_BGT = 2'b11;

   localparam logic [31:0] EPC_OFFSET = 32'd4;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_DONE = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_branch_cond.sv
// ============================================================================
// Module : pc_branch_cond
// Brief  : Combinational branch condition from branch_op and ALU flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_cond
   import pc_update_pkg::*;
(
   input  logic [1:0] branch_op,
   input  logic       alu_zero,
   input  logic       alu_gt,
   output logic       cond
);

   always_comb begin
      cond = 1'b0;
      case (branch_op)
         BR_BEQ:  cond = alu_zero;
         BR_BNE:  cond = !alu_zero;
         BR_BLE:  cond = alu_zero | !alu_gt;
         BR_BGT:  cond = alu_gt;
         default: cond = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ============================================================================
// Module : pc_update_unit
// Brief  : Architectural PC/EPC registers, commit/alignment pulses and the
//          instruction-fetch wait sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_update_unit
   import pc_update_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_LAT  = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_op,
   input  logic        alu_zero,
   input  logic        alu_gt,
   input  logic        epc_write,
   input  logic        fetch_req,
   output logic [31:0] pc_out,
   output logic [31:0] epc_out,
   output logic        pc_written,
   output logic        align_exc,
   output logic        fetch_busy,
   output logic        fetch_done
);

   // Counter holds the remaining WAIT cycles after the current one.
   localparam logic [3:0] LAT_RELOAD = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

   logic         cond;
   logic         take;
   logic         commit;
   logic         misaligned;

   logic [31:0]  pc_d, pc_q;
   logic [31:0]  epc_d, epc_q;
   logic         pc_written_d, pc_written_q;
   logic         align_exc_d, align_exc_q;
   fetch_state_t state_d, state_q;
   logic [3:0]   cnt_d, cnt_q;

   pc_branch_cond u_branch_cond (
      .branch_op (branch_op),
      .alu_zero  (alu_zero),
      .alu_gt    (alu_gt),
      .cond      (cond)
   );

   assign take       = pc_write | (pc_write_cond & cond);
   assign commit     = take & (pc_next[1:0] == 2'b00);
   assign misaligned = take & (pc_next[1:0] != 2'b00);

   always_comb begin
      pc_d         = pc_q;
      epc_d        = epc_q;
      pc_written_d = commit;
      align_exc_d  = misaligned;
      if (commit) begin
         pc_d = pc_next;
      end
      // A rejected target records the faulting PC itself, taking priority.
      if (misaligned) begin
         epc_d = pc_q;
      end else if (epc_write) begin
         epc_d = pc_q - EPC_OFFSET;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         FS_IDLE: begin
            if (fetch_req) begin
               if (MEM_LAT == 0) begin
                  state_d = FS_DONE;
               end else begin
                  state_d = FS_WAIT;
                  cnt_d   = LAT_RELOAD;
               end
            end
         end
         FS_WAIT: begin
            // A new PC restarts the fetch at the new address.
            if (commit) begin
               cnt_d = LAT_RELOAD;
            end else if (cnt_q == 4'd0) begin
               state_d = FS_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         FS_DONE: begin
            state_d = FS_IDLE;
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         epc_q        <= 32'd0;
         pc_written_q <= 1'b0;
         align_exc_q  <= 1'b0;
         state_q      <= FS_IDLE;
         cnt_q        <= 4'd0;
      end else begin
         pc_q         <= pc_d;
         epc_q        <= epc_d;
         pc_written_q <= pc_written_d;
         align_exc_q  <= align_exc_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

   assign pc_out     = pc_q;
   assign epc_out    = epc_q;
   assign pc_written = pc_written_q;
   assign align_exc  = align_exc_q;
   assign fetch_busy = (state_q == FS_WAIT);
   assign fetch_done = (state_q == FS_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
// Module : tb_pc_update_unit
// Brief  : Directed, table-driven bench for pc_update_unit (MEM_LAT 2 and 0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

   logic        clk;
   logic        reset;
   logic [31:0] pc_next;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  branch_op;
   logic        alu_zero;
   logic        alu_gt;
   logic        epc_write;
   logic        fetch_req;

   logic [31:0] pc_out, epc_out;
   logic        pc_written, align_exc, fetch_busy, fetch_done;
   logic [31:0] pc_out0, epc_out0;
   logic        pc_written0, align_exc0, fetch_busy0, fetch_done0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        pw;
      logic        pwc;
      logic [1:0]  bop;
      logic        z;
      logic        gt;
      logic [31:0] nxt;
      logic        take;
   } vec_t;

   vec_t vecs[14];

   pc_update_unit #(.RESET_PC(32'h0000_0100), .MEM_LAT(2)) dut (
      .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
      .alu_gt(alu_gt), .epc_write(epc_write), .fetch_req(fetch_req),
      .pc_out(pc_out), .epc_out(epc_out), .pc_written(pc_written),
      .align_exc(align_exc), .fetch_busy(fetch_busy), .fetch_done(fetch_done)
   );

   pc_update_unit #(.RESET_PC(32'h0000_0100), .MEM_LAT(0)) dut0 (
      .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
      .alu_gt(alu_gt), .epc_write(epc_write), .fetch_req(fetch_req),
      .pc_out(pc_out0), .epc_out(epc_out0), .pc_written(pc_written0),
      .align_exc(align_exc0), .fetch_busy(fetch_busy0), .fetch_done(fetch_done0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_op     = 2'b00;
      alu_zero      = 1'b0;
      alu_gt        = 1'b0;
      epc_write     = 1'b0;
      fetch_req     = 1'b0;
   endtask

   initial begin : main
      logic [31:0] exp_pc;

      // pw, pwc, bop, zero, gt, pc_next, expected commit
      vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0204, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0300, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_1000, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_1010, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_1020, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_1030, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_1040, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_1050, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0000_1060, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_1070, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_1080, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 32'h0000_1090, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_10A0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_10B0, 1'b0};

      clear_inputs();
      pc_next = 32'h0;
      reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_pc", pc_out, 32'h0000_0100);
      chk("reset_epc", epc_out, 32'h0);
      chk("reset_written", {31'd0, pc_written}, 32'd0);
      chk("reset_align", {31'd0, align_exc}, 32'd0);
      chk("reset_busy", {31'd0, fetch_busy}, 32'd0);
      chk("reset_done", {31'd0, fetch_done}, 32'd0);

      exp_pc = 32'h0000_0100;
      for (int i = 0; i < 14; i++) begin
         pc_write      = vecs[i].pw;
         pc_write_cond = vecs[i].pwc;
         branch_op     = vecs[i].bop;
         alu_zero      = vecs[i].z;
         alu_gt        = vecs[i].gt;
         pc_next       = vecs[i].nxt;
         step();
         if (vecs[i].take) exp_pc = vecs[i].nxt;
         chk($sformatf("vec%0d_written", i), {31'd0, pc_written}, {31'd0, vecs[i].take});
         chk($sformatf("vec%0d_pc", i), pc_out, exp_pc);
         clear_inputs();
         step();
         chk($sformatf("vec%0d_pulse_clear", i), {31'd0, pc_written}, 32'd0);
      end

      // Misaligned target with simultaneous epc_write.
      pc_write = 1'b1; pc_next = 32'h0000_0040;
      step();
      clear_inputs();
      step();
      chk("pre_align_pc", pc_out, 32'h0000_0040);
      pc_write = 1'b1; pc_next = 32'h0000_0046; epc_write = 1'b1;
      step();
      chk("align_pc", pc_out, 32'h0000_0040);
      chk("align_epc", epc_out, 32'h0000_0040);
      chk("align_exc", {31'd0, align_exc}, 32'd1);
      chk("align_no_written", {31'd0, pc_written}, 32'd0);
      pc_write = 1'b0;
      step();
      chk("epc_minus4", epc_out, 32'h0000_003C);
      chk("align_pulse_clear", {31'd0, align_exc}, 32'd0);
      clear_inputs();

      // EPC wraparound from PC 0.
      pc_write = 1'b1; pc_next = 32'h0;
      step();
      pc_write = 1'b0; epc_write = 1'b1;
      step();
      chk("epc_wrap", epc_out, 32'hFFFF_FFFC);
      clear_inputs();
      step();

      // Plain fetch, MEM_LAT=2; fetch_req held into WAIT must be ignored.
      fetch_req = 1'b1;
      step();
      chk("f1_busy1", {31'd0, fetch_busy}, 32'd1);
      chk("f1_done1", {31'd0, fetch_done}, 32'd0);
      chk("f0_done", {31'd0, fetch_done0}, 32'd1);
      chk("f0_busy", {31'd0, fetch_busy0}, 32'd0);
      step();
      fetch_req = 1'b0;
      chk("f1_busy2", {31'd0, fetch_busy}, 32'd1);
      chk("f0_done_clear", {31'd0, fetch_done0}, 32'd0);
      chk("f0_busy2", {31'd0, fetch_busy0}, 32'd0);
      step();
      chk("f1_busy3", {31'd0, fetch_busy}, 32'd0);
      chk("f1_done3", {31'd0, fetch_done}, 32'd1);
      step();
      chk("f1_done4", {31'd0, fetch_done}, 32'd0);
      chk("f1_idle_busy", {31'd0, fetch_busy}, 32'd0);

      // Fetch restarted by a committed PC write in the 2nd busy cycle.
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("f2_busy1", {31'd0, fetch_busy}, 32'd1);
      step();
      chk("f2_busy2", {31'd0, fetch_busy}, 32'd1);
      pc_write = 1'b1; pc_next = 32'h0000_0080;
      step();
      pc_write = 1'b0;
      chk("f2_written", {31'd0, pc_written}, 32'd1);
      chk("f2_pc", pc_out, 32'h0000_0080);
      chk("f2_busy3", {31'd0, fetch_busy}, 32'd1);
      chk("f2_done3", {31'd0, fetch_done}, 32'd0);
      step();
      chk("f2_busy4", {31'd0, fetch_busy}, 32'd1);
      chk("f2_done4", {31'd0, fetch_done}, 32'd0);
      step();
      chk("f2_busy5", {31'd0, fetch_busy}, 32'd0);
      chk("f2_done5", {31'd0, fetch_done}, 32'd1);
      step();
      chk("f2_done6", {31'd0, fetch_done}, 32'd0);

      // Reset in WAIT aborts immediately with no done pulse.
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("f3_busy1", {31'd0, fetch_busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("f3_async_busy", {31'd0, fetch_busy}, 32'd0);
      chk("f3_async_pc", pc_out, 32'h0000_0100);
      step();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("f3_no_done%0d", k), {30'd0, fetch_done, fetch_busy}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
